// File: rtl/register_bank16_pkg.sv
// Shared definitions for the 16-entry register bank: widths, register count,
// program-counter alias index and the register-index type.
package register_bank16_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS       = 16;
    localparam int PC_INDEX_DEF   = 15;

    typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/onehot_encoder16.sv
// Converts a 16-bit write select into {valid, index}; valid only when exactly
// one bit is set, index is then the position of that bit.
module onehot_encoder16
    import register_bank16_pkg::*;
(
    input  logic [NUM_REGS-1:0] onehot,
    output logic                valid,
    output reg_idx_t            index
);

    logic [4:0] ones_count;

    always_comb begin
        ones_count = '0;
        index      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (onehot[i]) begin
                ones_count = ones_count + 5'd1;
                index      = reg_idx_t'(i);
            end
        end
        valid = (ones_count == 5'd1);
    end

endmodule

// File: rtl/register_bank16.sv
// 15-entry register bank with a program-counter alias, three combinational
// read ports, select-error flag and write counter. Define REGFILE_BYPASS_EN
// to forward same-cycle write data to the read ports.
module register_bank16
    import register_bank16_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PC_INDEX   = PC_INDEX_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [15:0]           wr_onehot,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [3:0]            ra1,
    input  logic [3:0]            ra2,
    input  logic [3:0]            ra3,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] rd3,
    output logic                  onehot_err,
    output logic [15:0]           wr_count
);

    localparam reg_idx_t PC_IDX = reg_idx_t'(PC_INDEX);

    logic            sel_valid;
    reg_idx_t        wr_index;
    logic            wr_commit;
    logic            onehot_err_reg;
    logic [15:0]     wr_count_reg;
    logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
    reg_idx_t              ra_sel [3];
    logic [DATA_WIDTH-1:0] rd_data [3];

    onehot_encoder16 u_encoder (
        .onehot (wr_onehot),
        .valid  (sel_valid),
        .index  (wr_index)
    );

    // Reset wins over a simultaneous write, so a write during reset is never committed.
    assign wr_commit = we && sel_valid && (wr_index != PC_IDX) && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi != PC_INDEX) begin : g_store
                logic [DATA_WIDTH-1:0] value_reg;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        value_reg <= '0;
                    end else if (wr_commit && (wr_index == reg_idx_t'(gi))) begin
                        value_reg <= wd;
                    end
                end
                assign reg_q[gi] = value_reg;
            end else begin : g_pc
                assign reg_q[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_err_reg <= 1'b0;
            wr_count_reg   <= '0;
        end else begin
            onehot_err_reg <= we && !sel_valid;
            if (wr_commit) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    assign ra_sel[0] = ra1;
    assign ra_sel[1] = ra2;
    assign ra_sel[2] = ra3;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_read
            logic [DATA_WIDTH-1:0] rd_next;
            always_comb begin
                rd_next = reg_q[ra_sel[gi]];
`ifdef REGFILE_BYPASS_EN
                if (wr_commit && (ra_sel[gi] == wr_index)) begin
                    rd_next = wd;
                end
`else
`endif
                if (ra_sel[gi] == PC_IDX) begin
                    rd_next = pc_in;
                end
            end
            assign rd_data[gi] = rd_next;
        end
    endgenerate

    assign rd1        = rd_data[0];
    assign rd2        = rd_data[1];
    assign rd3        = rd_data[2];
    assign onehot_err = onehot_err_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_register_bank16.sv
// Directed bench for register_bank16: a behavioural model checked every cycle
// plus literal expectations at the key scenario points.
module tb_register_bank16;

    localparam int PCI = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [15:0] wr_onehot;
    logic [31:0] wd;
    logic [3:0]  ra1, ra2, ra3;
    logic [31:0] pc_in;
    logic [31:0] rd1, rd2, rd3;
    logic        onehot_err;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [31:0] m_regs [16];
    logic        m_err;
    logic [15:0] m_cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_bank16 dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wr_onehot  (wr_onehot),
        .wd         (wd),
        .ra1        (ra1),
        .ra2        (ra2),
        .ra3        (ra3),
        .pc_in      (pc_in),
        .rd1        (rd1),
        .rd2        (rd2),
        .rd3        (rd3),
        .onehot_err (onehot_err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    function automatic int target_of(input logic [15:0] oh);
        for (int i = 0; i < 16; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // Expected read value from the model state and the current inputs.
    function automatic logic [31:0] model_rd(input logic [3:0] ra);
        if (int'(ra) == PCI) return pc_in;
        if (BYPASS && !reset && we && $countones(wr_onehot) == 1
            && target_of(wr_onehot) == int'(ra)) return wd;
        return m_regs[ra];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
            m_err = 1'b0;
            m_cnt = 16'd0;
        end else if (we) begin
            if ($countones(wr_onehot) == 1) begin
                m_err = 1'b0;
                if (target_of(wr_onehot) != PCI) begin
                    m_regs[target_of(wr_onehot)] = wd;
                    m_cnt = m_cnt + 16'd1;
                end
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_err = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rd1", rd1, model_rd(ra1));
            chk("model_rd2", rd2, model_rd(ra2));
            chk("model_rd3", rd3, model_rd(ra3));
            chk("model_err", {31'd0, onehot_err}, {31'd0, m_err});
            chk("model_cnt", {16'd0, wr_count}, {16'd0, m_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [15:0] oh, input logic [31:0] d);
        we = w;
        wr_onehot = oh;
        wd = d;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wr_onehot = '0; wd = '0;
        ra1 = '0; ra2 = '0; ra3 = '0; pc_in = '0;
        tick();
        check_en = 1'b1;
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i);
            #1;
            chk("reset_rd1", rd1, 32'd0);
        end
        chk("reset_err", {31'd0, onehot_err}, 32'd0);
        chk("reset_cnt", {16'd0, wr_count}, 32'd0);
        $display("txn reset: rd1 R0..R14 cnt=%0d", wr_count);

        // Single valid write to R3
        drive(1'b1, 16'h0008, 32'hDEADBEEF);
        tick();
        drive(1'b0, 16'h0000, 32'h0);
        ra2 = 4'd3;
        #1;
        chk("wr_r3_rd2", rd2, 32'hDEADBEEF);
        chk("wr_r3_cnt", {16'd0, wr_count}, 32'd1);
        $display("txn write R3: rd2=%08h cnt=%0d", rd2, wr_count);

        // Invalid selects: two bits, then none
        ra1 = 4'd0; ra2 = 4'd2;
        drive(1'b1, 16'h0005, 32'hCAFEF00D);
        tick();
        drive(1'b0, 16'h0005, 32'h0);
        #1;
        chk("multi_err", {31'd0, onehot_err}, 32'd1);
        chk("multi_r0", rd1, 32'd0);
        chk("multi_r2", rd2, 32'd0);
        chk("multi_cnt", {16'd0, wr_count}, 32'd1);
        tick();
        chk("multi_err_clear", {31'd0, onehot_err}, 32'd0);
        drive(1'b1, 16'h0000, 32'hCAFEF00D);
        tick();
        drive(1'b0, 16'h0000, 32'h0);
        #1;
        chk("zero_err", {31'd0, onehot_err}, 32'd1);
        chk("zero_cnt", {16'd0, wr_count}, 32'd1);
        tick();
        chk("zero_err_clear", {31'd0, onehot_err}, 32'd0);
        $display("txn invalid selects: err pulses seen, cnt=%0d", wr_count);

        // Write aimed at the PC alias is dropped
        pc_in = 32'h00000108; ra3 = 4'd15;
        drive(1'b1, 16'h8000, 32'h12345678);
        #1;
        chk("pc_rd3", rd3, 32'h00000108);
        tick();
        drive(1'b0, 16'h0000, 32'h0);
        #1;
        chk("pc_err", {31'd0, onehot_err}, 32'd0);
        chk("pc_cnt", {16'd0, wr_count}, 32'd1);
        chk("pc_rd3_after", rd3, 32'h00000108);
        $display("txn pc write: rd3=%08h cnt=%0d", rd3, wr_count);

        // Same-cycle write/read of R5
        drive(1'b1, 16'h0020, 32'h11111111);
        tick();
        drive(1'b1, 16'h0020, 32'hA5A5A5A5);
        ra1 = 4'd5;
        #1;
        chk("same_cycle_rd1", rd1, BYPASS ? 32'hA5A5A5A5 : 32'h11111111);
        tick();
        drive(1'b0, 16'h0000, 32'h0);
        #1;
        chk("after_edge_rd1", rd1, 32'hA5A5A5A5);
        chk("same_cycle_cnt", {16'd0, wr_count}, 32'd3);
        $display("txn same-cycle R5: rd1=%08h cnt=%0d", rd1, wr_count);

        // Reset beats a simultaneous write; reads show pre-edge contents during reset
        reset = 1'b1;
        drive(1'b1, 16'h0002, 32'hFFFFFFFF);
        ra2 = 4'd1;
        #1;
        chk("in_reset_rd1", rd1, 32'hA5A5A5A5);
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0000, 32'h0);
        #1;
        chk("rst_write_r1", rd2, 32'd0);
        chk("rst_write_r5", rd1, 32'd0);
        chk("rst_write_cnt", {16'd0, wr_count}, 32'd0);
        $display("txn reset+write: rd2=%08h cnt=%0d", rd2, wr_count);

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 16'(1 << (i % 15)), 32'(i));
            tick();
        end
        drive(1'b0, 16'h0000, 32'h0);
        #1;
        chk("cnt_ffff", {16'd0, wr_count}, 32'h0000FFFF);
        drive(1'b1, 16'h0001, 32'h0BADC0DE);
        tick();
        drive(1'b0, 16'h0000, 32'h0);
        ra1 = 4'd0;
        #1;
        chk("cnt_wrap", {16'd0, wr_count}, 32'd0);
        chk("wrap_r0", rd1, 32'h0BADC0DE);
        $display("txn counter wrap: cnt=%0d", wr_count);

        tick();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank16.md
REGISTER_BANK16 -- requirements
Module: register_bank16

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register and data-port width in bits.
REQ-002 SHALL provide parameter PC_INDEX, default 15, register index aliased to the program counter input.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port we  input  1  global write enable from control unit.
REQ-006 SHALL provide port wr_onehot  input  16  decoded write-register select, bit n selects register n (decoder out0..out15).
REQ-007 SHALL provide port wd  input  DATA_WIDTH  write data.
REQ-008 SHALL provide ports ra1, ra2, ra3  input  4 each  read-address selects.
REQ-009 SHALL provide port pc_in  input  DATA_WIDTH  value returned for reads of PC_INDEX.
REQ-010 SHALL provide ports rd1, rd2, rd3  output  DATA_WIDTH each  read data.
REQ-011 SHALL provide port onehot_err  output  1  registered flag: write attempted with invalid select.
REQ-012 SHALL provide port wr_count  output  16  registered count of committed writes.

Function
REQ-013 Storage SHALL be registers R0..R14; PC_INDEX has no storage.
REQ-014 Write SHALL commit on rising clk when we=1 and wr_onehot has exactly one bit set at position n != PC_INDEX; Rn <= wd.
REQ-015 wr_onehot with bit PC_INDEX as its only set bit SHALL be silently dropped: no write, no error, no count.
REQ-016 we=1 with wr_onehot zero or with >1 bit set SHALL perform no write and set onehot_err=1 for exactly the next cycle.
REQ-017 we=0 SHALL perform no write and clear onehot_err on the next edge regardless of wr_onehot.
REQ-018 Reads SHALL be combinational (zero latency); rdK = R[raK] for raK != PC_INDEX, rdK = pc_in for raK = PC_INDEX.
REQ-019 All three read ports SHALL operate independently, including identical addresses.
REQ-020 wr_count SHALL increment by 1 on each committed write (REQ-014 only), wrapping 0xFFFF -> 0x0000.
REQ-021 Read of a register being written in the same cycle SHALL follow REQ-031/REQ-032.

Reset
REQ-022 reset=1 at a rising edge SHALL clear R0..R14 to 0, onehot_err to 0, wr_count to 0.
REQ-023 reset SHALL take priority over any simultaneous write; the write is lost and not counted.
REQ-024 During reset, rdK SHALL reflect the current (pre-edge) register contents; reads of PC_INDEX still return pc_in.
REQ-025 First write SHALL be accepted on the first rising edge with reset=0.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 With REGFILE_BYPASS_EN defined: if a valid write (REQ-014) targets Rn and raK=n in the same cycle, rdK SHALL equal wd combinationally.
REQ-032 Without REGFILE_BYPASS_EN: rdK SHALL return the pre-write value of Rn until after the edge; no wd-to-rd path SHALL exist.

Structure
REQ-040 A shared package SHALL hold DATA_WIDTH default, NUM_REGS=16, PC_INDEX default, and the 4-bit register-index typedef.
REQ-041 One sub-module onehot_encoder16 SHALL convert wr_onehot to {valid, index[3:0]}, valid=1 only for exactly one set bit.
REQ-042 Register array, error flag, counter and read muxes SHALL reside in register_bank16.

Verification
REQ-050 reset 1 cycle, then read ra1=0..14 -> rd1=0 for all; onehot_err=0; wr_count=0.
REQ-051 we=1, wr_onehot=0x0008, wd=0xDEADBEEF; next cycle ra2=3 -> rd2=0xDEADBEEF, wr_count=1.
REQ-052 we=1, wr_onehot=0x0005 -> no register changes, onehot_err=1 for exactly one cycle, wr_count unchanged; repeat with wr_onehot=0x0000 -> same.
REQ-053 we=1, wr_onehot=0x8000, wd=0x12345678, pc_in=0x00000108, ra3=15 -> rd3=0x00000108, onehot_err=0, wr_count unchanged.
REQ-054 same-cycle write R5=0xA5A5A5A5 with ra1=5 (old 0x11111111) -> rd1=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11111111 without; both 0xA5A5A5A5 after edge.
REQ-055 reset=1 with we=1, wr_onehot=0x0002, wd=0xFFFFFFFF -> R1=0, wr_count=0; then 65536 valid writes -> wr_count wraps to 0.
